// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the handshaked data memory: FSM encoding,
// read-latency legality and the byte-strobe merge used by the storage array.
package data_mem_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   // Widest word the strobe merge supports; callers zero-extend and truncate.
   localparam int MAX_W     = 256;
   localparam int MAX_LANES = MAX_W / 8;

   function automatic bit rd_lat_ok(input int lat);
      return (lat == 1) || (lat == 2);
   endfunction

   function automatic logic [MAX_W-1:0] strb_merge(input logic [MAX_W-1:0]     old_w,
                                                   input logic [MAX_W-1:0]     wdata,
                                                   input logic [MAX_LANES-1:0] wstrb);
      logic [MAX_W-1:0] res;
      res = old_w;
      for (int i = 0; i < MAX_LANES; i++) begin
         if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/data_mem_array.sv
// Plain single-port synchronous RAM with per-byte-lane write enables and a
// registered read port. Contents are never reset.
module data_mem_array
   import data_mem_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DATA_W/8-1:0]   be,
   input  logic                  re,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     wdata,
   output logic [DATA_W-1:0]     rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Caller guarantees addr < DEPTH whenever we or re is set.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= DATA_W'(strb_merge(MAX_W'(mem[addr]), MAX_W'(wdata), MAX_LANES'(be)));
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/data_mem_hs.sv
// Data memory behind a valid/ready request port with a fixed-latency read
// response, byte strobes, out-of-range flagging and a post-reset clear pass.
module data_mem_hs
   import data_mem_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256,
   parameter int RD_LAT = 1,
   parameter int CLR_EN = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [DATA_W/8-1:0]   req_wstrb,
   output logic                  rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err,
   output logic                  init_done
);

   localparam int LANES = DATA_W / 8;
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LAST    = (ADDR_W+1)'(DEPTH - 1);

   generate
      if (!rd_lat_ok(RD_LAT)) begin : g_bad_lat
         $fatal(1, "data_mem_hs: RD_LAT must be 1 or 2");
      end
   endgenerate

   // Handshake: a request transfers on a rising edge where req_valid & req_ready;
   // req_ready is a pure function of state and never looks at req_valid.
   state_t              state;
   logic [ADDR_W:0]     clr_cnt;
   logic                acc;
   logic                in_range;
   logic                clearing;
   logic                arr_we;
   logic                arr_re;
   logic [LANES-1:0]    arr_be;
   logic [ADDR_W-1:0]   arr_addr;
   logic [DATA_W-1:0]   arr_wdata;
   logic [DATA_W-1:0]   arr_rdata;
   logic                v1;
   logic                e1;

   assign acc      = req_valid & req_ready;
   assign in_range = {1'b0, req_addr} < DEPTH_X;
   assign clearing = (state == ST_CLEAR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= (CLR_EN != 0) ? ST_CLEAR : ST_RUN;
         clr_cnt   <= '0;
         req_ready <= 1'b0;
         init_done <= 1'b0;
      end else begin
         case (state)
            ST_CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == LAST) begin
                  state     <= ST_RUN;
                  req_ready <= 1'b1;
                  init_done <= 1'b1;
               end
            end
            default: begin
               req_ready <= 1'b1;
               init_done <= 1'b1;
            end
         endcase
      end
   end

   // The clear pass owns the write port while it runs; requests cannot be accepted then.
   always_comb begin
      arr_we    = acc & req_we & in_range;
      arr_re    = acc & ~req_we & in_range;
      arr_be    = req_wstrb;
      arr_addr  = req_addr;
      arr_wdata = req_wdata;
      if (clearing) begin
         arr_we    = 1'b1;
         arr_re    = 1'b0;
         arr_be    = '1;
         arr_addr  = clr_cnt[ADDR_W-1:0];
         arr_wdata = '0;
      end
   end

   data_mem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk   (clk),
      .we    (arr_we),
      .be    (arr_be),
      .re    (arr_re),
      .addr  (arr_addr),
      .wdata (arr_wdata),
      .rdata (arr_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         e1 <= 1'b0;
      end else begin
         v1 <= acc & ~req_we;
         e1 <= acc & ~req_we & ~in_range;
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic              v2;
         logic              e2;
         logic [DATA_W-1:0] d2;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v2 <= 1'b0;
               e2 <= 1'b0;
               d2 <= '0;
            end else begin
               v2 <= v1;
               e2 <= e1;
               d2 <= (v1 & ~e1) ? arr_rdata : '0;
            end
         end

         assign rsp_valid = v2;
         assign rsp_err   = e2;
         assign rsp_rdata = d2;
      end else begin : g_lat1
         // RAM output register is the response register; gate it so idle and error cycles read 0.
         assign rsp_valid = v1;
         assign rsp_err   = e1;
         assign rsp_rdata = (v1 & ~e1) ? arr_rdata : '0;
      end
   endgenerate

endmodule

// File: tb/tb_data_mem_hs.sv
// Bench for data_mem_hs: a default instance and a 32-bit / DEPTH=200 / RD_LAT=2
// instance share one request stream and are checked against a memory model.
module tb_data_mem_hs;

   localparam int DA = 256;
   localparam int DB = 200;
   localparam int LB = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [7:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_wstrb = '0;

   logic        rdy_a, rv_a, re_a, done_a;
   logic [7:0]  rd_a;
   logic        rdy_b, rv_b, re_b, done_b;
   logic [31:0] rd_b;

   always #5 clk = ~clk;

   data_mem_hs u_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (rdy_a),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata[7:0]),
      .req_wstrb (req_wstrb[0:0]),
      .rsp_valid (rv_a),
      .rsp_rdata (rd_a),
      .rsp_err   (re_a),
      .init_done (done_a)
   );

   data_mem_hs #(
      .DATA_W (32),
      .ADDR_W (8),
      .DEPTH  (DB),
      .RD_LAT (LB),
      .CLR_EN (1)
   ) u_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (rdy_b),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_valid (rv_b),
      .rsp_rdata (rd_b),
      .rsp_err   (re_b),
      .init_done (done_b)
   );

   // Reference model: word arrays plus expected-response queues {due_cycle, err, data}
   logic [7:0]  mem_a [DA];
   logic [31:0] mem_b [DB];
   logic [64:0] exp_a_q[$];
   logic [64:0] exp_b_q[$];
   int cnt_a, cnt_b, cyc;
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      cnt_a = 0;
      cnt_b = 0;
      exp_a_q.delete();
      exp_b_q.delete();
      for (int i = 0; i < DA; i++) mem_a[i] = '0;
      for (int i = 0; i < DB; i++) mem_b[i] = '0;
   endtask

   task automatic model_edge();
      logic [31:0] m;
      cyc++;
      if (req_valid && cnt_a >= DA) begin
         if (req_we) begin
            if (req_wstrb[0]) mem_a[req_addr] = req_wdata[7:0];
         end else begin
            exp_a_q.push_back({32'(cyc), 1'b0, 24'h0, mem_a[req_addr]});
         end
      end
      if (req_valid && cnt_b >= DB) begin
         if (int'(req_addr) < DB) begin
            if (req_we) begin
               m = mem_b[req_addr];
               for (int i = 0; i < 4; i++) if (req_wstrb[i]) m[8*i +: 8] = req_wdata[8*i +: 8];
               mem_b[req_addr] = m;
            end else begin
               exp_b_q.push_back({32'(cyc + LB - 1), 1'b0, mem_b[req_addr]});
            end
         end else if (!req_we) begin
            exp_b_q.push_back({32'(cyc + LB - 1), 1'b1, 32'h0});
         end
      end
      if (cnt_a < DA) cnt_a++;
      if (cnt_b < DB) cnt_b++;
   endtask

   task automatic check_outputs();
      logic [64:0] e;
      check("a_ready", rdy_a, cnt_a >= DA);
      check("a_init_done", done_a, cnt_a >= DA);
      check("b_ready", rdy_b, cnt_b >= DB);
      check("b_init_done", done_b, cnt_b >= DB);
      if (exp_a_q.size() > 0 && exp_a_q[0][64:33] == 32'(cyc)) begin
         e = exp_a_q.pop_front();
         check("a_rsp_valid", rv_a, 1);
         check("a_rsp_rdata", rd_a, e[7:0]);
         check("a_rsp_err", re_a, e[32]);
      end else begin
         check("a_idle_valid", rv_a, 0);
         check("a_idle_rdata", rd_a, 0);
         check("a_idle_err", re_a, 0);
      end
      if (exp_b_q.size() > 0 && exp_b_q[0][64:33] == 32'(cyc)) begin
         e = exp_b_q.pop_front();
         check("b_rsp_valid", rv_b, 1);
         check("b_rsp_rdata", rd_b, e[31:0]);
         check("b_rsp_err", re_b, e[32]);
      end else begin
         check("b_idle_valid", rv_b, 0);
         check("b_idle_rdata", rd_b, 0);
         check("b_idle_err", re_b, 0);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst_n) model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic req(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_wstrb = wstrb;
      cycle();
      req_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_a_valid"}, rv_a, 0);
      check({tag, "_a_rdata"}, rd_a, 0);
      check({tag, "_a_err"}, re_a, 0);
      check({tag, "_a_ready"}, rdy_a, 0);
      check({tag, "_a_done"}, done_a, 0);
      check({tag, "_b_valid"}, rv_b, 0);
      check({tag, "_b_rdata"}, rd_b, 0);
      check({tag, "_b_ready"}, rdy_b, 0);
      check({tag, "_b_done"}, done_b, 0);
   endtask

   // Asserted off the clock edge so the drop is seen before any edge
   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      req_valid = 1'b0;
      #1;
      check_reset_outputs(tag);
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Clear phase with junk requests that must be ignored until ready
   task automatic wait_ready();
      for (int i = 0; i < DA; i++) begin
         req_valid = (i < DB) ? 1'($urandom_range(0, 1)) : 1'b0;
         req_we    = 1'($urandom_range(0, 1));
         req_addr  = 8'($urandom_range(0, 255));
         req_wdata = $urandom;
         req_wstrb = 4'($urandom_range(0, 15));
         cycle();
      end
      req_valid = 1'b0;
   endtask

   function automatic logic [7:0] rand_addr();
      case ($urandom_range(0, 3))
         0:       return 8'($urandom_range(0, 15));
         1:       return 8'($urandom_range(190, 215));
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   task automatic random_traffic(input int n);
      for (int i = 0; i < n; i++) begin
         req_valid = ($urandom_range(0, 3) != 0);
         req_we    = 1'($urandom_range(0, 1));
         req_addr  = rand_addr();
         req_wdata = $urandom;
         req_wstrb = 4'($urandom_range(0, 15));
         cycle();
      end
      req_valid = 1'b0;
   endtask

   initial begin
      cyc = 0;
      model_reset();
      #1;
      check_reset_outputs("por");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // T1: clear takes exactly DEPTH edges, then every word reads zero
      wait_ready();
      for (int a = 0; a < DA; a++) req(1'b0, 8'(a), 32'h0, 4'h0);
      idle(LB + 1);

      // T2: write then read back
      req(1'b1, 8'd0, 32'h1, 4'hF);
      req(1'b1, 8'd1, 32'h7, 4'hF);
      req(1'b0, 8'd0, 32'h0, 4'h0);
      req(1'b0, 8'd1, 32'h0, 4'h0);
      idle(3);

      // T3: byte strobes and read-after-write on the next cycle
      req(1'b1, 8'd5, 32'hAABBCCDD, 4'hF);
      req(1'b1, 8'd5, 32'h11223344, 4'b0101);
      req(1'b0, 8'd5, 32'h0, 4'h0);
      idle(3);

      // T4: out-of-range write and read, last in-range word
      req(1'b1, 8'd199, 32'hCAFE0199, 4'hF);
      req(1'b1, 8'd210, 32'hDEADBEEF, 4'hF);
      req(1'b0, 8'd210, 32'h0, 4'h0);
      req(1'b0, 8'd199, 32'h0, 4'h0);
      req(1'b1, 8'd5, 32'h0, 4'h0);
      req(1'b0, 8'd5, 32'h0, 4'h0);
      idle(3);

      // T5: streaming reads back to back
      for (int i = 0; i < 4; i++) req(1'b1, 8'(10 + i), 32'(16 + i), 4'hF);
      for (int i = 0; i < 4; i++) req(1'b0, 8'(10 + i), 32'h0, 4'h0);
      idle(3);

      random_traffic(800);
      idle(3);

      // T6: reset partway through clear, then with reads in flight
      do_reset("rst_run");
      idle(100);
      do_reset("rst_clr100");
      wait_ready();
      req(1'b1, 8'd3, 32'h5A5A5A5A, 4'hF);
      req(1'b0, 8'd3, 32'h0, 4'h0);
      req(1'b0, 8'd3, 32'h0, 4'h0);
      do_reset("rst_inflight");
      cycle();
      wait_ready();
      for (int a = 0; a < 8; a++) req(1'b0, 8'(a), 32'h0, 4'h0);
      random_traffic(200);
      idle(LB + 2);

      check("a_queue_drained", 64'(exp_a_q.size()), 0);
      check("b_queue_drained", 64'(exp_b_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
